// File: rtl/dmem_copy_engine_pkg.sv
// Shared constants and types for the data-memory copy/fill engine.
// Memory geometry here matches the data memory and CPU datapath.
package dmem_copy_engine_pkg;

    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 16;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_FIN
    } dce_state_t;

endpackage

// File: rtl/dmem_copy_engine_if.sv
// Command and memory-bus bundle for the copy engine.
// master = engine side, slave = host/memory side.
interface dmem_copy_engine_if
    import dmem_copy_engine_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
);

    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W:0]   length;
    logic [DATA_W-1:0] fill_value;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   words_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  start,
        input  mode,
        input  src_addr,
        input  dst_addr,
        input  length,
        input  fill_value,
        input  mem_rdata,
        output busy,
        output done,
        output words_done,
        output mem_addr,
        output mem_wdata,
        output mem_we
    );

    modport slave (
        output start,
        output mode,
        output src_addr,
        output dst_addr,
        output length,
        output fill_value,
        output mem_rdata,
        input  busy,
        input  done,
        input  words_done,
        input  mem_addr,
        input  mem_wdata,
        input  mem_we
    );

endinterface

// File: rtl/dmem_addr_gen.sv
// Address pointer with up/down step, modulo wrap and remaining-word count.
module dmem_addr_gen #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W:0]   i_len,
    input  logic              i_down,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_ptr,
    output logic [ADDR_W:0]   o_rem
);

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_rem;
    logic              r_down;

    // Descending runs start at the top word; the add/sub wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= '0;
            r_rem  <= '0;
            r_down <= 1'b0;
        end else if (i_load) begin
            r_down <= i_down;
            r_rem  <= i_len;
            r_ptr  <= i_down ? i_base + i_len[ADDR_W-1:0] - PTR_ONE
                             : i_base;
        end else if (i_step && (r_rem != '0)) begin
            r_ptr <= r_down ? r_ptr - PTR_ONE : r_ptr + PTR_ONE;
            r_rem <= r_rem - CNT_ONE;
        end
    end

    assign o_ptr = r_ptr;
    assign o_rem = r_rem;

endmodule

// File: rtl/dmem_copy_engine.sv
// Block COPY/FILL master for the data memory.
// Drives the memory pins while busy; reads through its combinational port.
module dmem_copy_engine
    import dmem_copy_engine_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    dmem_copy_engine_if.master bus
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    dce_state_t        r_state;
    logic              r_mode;
    logic [DATA_W-1:0] r_fill;
    logic [DATA_W-1:0] r_hold;
    logic              r_busy;
    logic              r_done;
    logic [CNT_W-1:0]  r_words;

    logic              w_accept;
    logic [CNT_W-1:0]  w_len;
    logic [ADDR_W-1:0] w_diff;
    logic              w_down;
    logic              w_last;
    logic [ADDR_W-1:0] w_src_ptr;
    logic [ADDR_W-1:0] w_dst_ptr;
    logic [CNT_W-1:0]  w_src_rem;
    logic [CNT_W-1:0]  w_dst_rem;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_mem_we;

    assign w_accept = (r_state == ST_IDLE) && bus.start;
    assign w_len    = (bus.length > MAX_LEN) ? MAX_LEN : bus.length;
    assign w_diff   = bus.dst_addr - bus.src_addr;

    // Destination ahead of source inside the block: copy top-down.
    assign w_down = (bus.mode == MODE_COPY) && (w_diff != '0) &&
                    ({1'b0, w_diff} < w_len);

    dmem_addr_gen #(.ADDR_W(ADDR_W)) u_src (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept),
        .i_base (bus.src_addr),
        .i_len  (w_len),
        .i_down (w_down),
        .i_step (r_state == ST_READ),
        .o_ptr  (w_src_ptr),
        .o_rem  (w_src_rem)
    );

    dmem_addr_gen #(.ADDR_W(ADDR_W)) u_dst (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept),
        .i_base (bus.dst_addr),
        .i_len  (w_len),
        .i_down (w_down),
        .i_step (r_state == ST_WRITE),
        .o_ptr  (w_dst_ptr),
        .o_rem  (w_dst_rem)
    );

    // COPY: source already stepped past its last word when the write happens.
    assign w_last = (r_mode == MODE_COPY) ? (w_src_rem == '0)
                                          : (w_dst_rem == CNT_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_COPY;
            r_fill  <= '0;
            r_hold  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_words <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_mode  <= bus.mode;
                        r_fill  <= bus.fill_value;
                        r_words <= '0;
                        if (w_len == '0) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= (bus.mode == MODE_FILL) ? ST_WRITE
                                                               : ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    r_hold  <= bus.mem_rdata;
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_words <= r_words + CNT_ONE;
                    if (w_last) begin
                        r_state <= ST_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= (r_mode == MODE_COPY) ? ST_READ : ST_WRITE;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Pins depend only on registered state so they hold across the write negedge.
    always_comb begin
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_we    = 1'b0;
        unique case (1'b1)
            (r_state == ST_READ): begin
                w_mem_addr = w_src_ptr;
            end
            (r_state == ST_WRITE): begin
                w_mem_addr  = w_dst_ptr;
                w_mem_wdata = (r_mode == MODE_FILL) ? r_fill : r_hold;
                w_mem_we    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.words_done = r_words;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = w_mem_wdata;
    assign bus.mem_we     = w_mem_we;

endmodule
